// File: rtl/npu_pkg.sv
// Shared definitions for the NPU operand feeder.
// Contents: FSM state encoding, word/byte geometry, little-endian byte select.
package npu_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Byte idx of a word, little-endian: byte 0 = bits [7:0].
  function automatic logic [BYTE_W-1:0] le_byte(input logic [WORD_W-1:0] word,
                                                input logic [BIDX_W-1:0] idx);
    le_byte = word[{idx, 3'b000} +: BYTE_W];
  endfunction

endpackage

// File: rtl/npu_operand_feeder_if.sv
// Operand SRAM read bus for the NPU operand feeder (one port per operand).
// master: feeder side (drives read enables/addresses, receives read data).
// slave : SRAM side. Read data is valid the cycle after the read enable.
interface npu_operand_feeder_if #(
  parameter int unsigned ADDR_W = 12
);

  logic                       MEM_A_RE;
  logic [ADDR_W-1:0]          MEM_A_ADDR;
  logic [npu_pkg::WORD_W-1:0] MEM_A_RDATA;
  logic                       MEM_B_RE;
  logic [ADDR_W-1:0]          MEM_B_ADDR;
  logic [npu_pkg::WORD_W-1:0] MEM_B_RDATA;

  modport master (
    output MEM_A_RE, MEM_A_ADDR, MEM_B_RE, MEM_B_ADDR,
    input  MEM_A_RDATA, MEM_B_RDATA
  );

  modport slave (
    input  MEM_A_RE, MEM_A_ADDR, MEM_B_RE, MEM_B_ADDR,
    output MEM_A_RDATA, MEM_B_RDATA
  );

endinterface

// File: rtl/npu_word_unpacker.sv
// Splits 32-bit operand words into a byte stream, little-endian.
// Holds the word being unpacked plus one prefetched word so the stream has no
// bubbles at word boundaries.
// Ports: CLK, rst_x; rdata (SRAM read data); load_nxt (capture rdata into the
// next-word register); advance (emit one byte); src_rdata (byte 0 taken
// straight from rdata instead of the next-word register); byte_idx (byte to
// emit); elem (registered output byte, holds while advance is low).
module npu_word_unpacker
  import npu_pkg::*;
(
  input  logic              CLK,
  input  logic              rst_x,
  input  logic [WORD_W-1:0] rdata,
  input  logic              load_nxt,
  input  logic              advance,
  input  logic              src_rdata,
  input  logic [BIDX_W-1:0] byte_idx,
  output logic [BYTE_W-1:0] elem
);

  logic [WORD_W-1:0] cur_word;
  logic [WORD_W-1:0] nxt_word;
  logic [WORD_W-1:0] src_word_c;

  // Byte 0 starts a new word; later bytes come from the word already latched.
  always_comb begin
    src_word_c = cur_word;
    if (byte_idx == '0) begin
      src_word_c = src_rdata ? rdata : nxt_word;
    end
  end

  always_ff @(posedge CLK or negedge rst_x) begin
    if (!rst_x) begin
      cur_word <= '0;
      nxt_word <= '0;
      elem     <= '0;
    end else begin
      if (load_nxt) begin
        nxt_word <= rdata;
      end
      if (advance) begin
        elem <= le_byte(src_word_c, byte_idx);
        if (byte_idx == '0) begin
          cur_word <= src_word_c;
        end
      end
    end
  end

endmodule

// File: rtl/npu_operand_feeder.sv
// Feeds operand tensors A and B from two word SRAMs to the NPU core, one byte
// element of each per cycle, with start/busy/done handshake to the sequencer.
// Ports: CLK, rst_x (async, active-low); START/LEN/A_BASE/B_BASE job request;
// ABORT cancels a job; PAUSE freezes the stream; mem = SRAM read bus (master);
// INPUT_EN/A_IN/B_IN element stream; BUSY/DONE job status. All outputs registered.
module npu_operand_feeder
  import npu_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 16
)(
  input  logic                 CLK,
  input  logic                 rst_x,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic                 PAUSE,
  input  logic [LEN_W-1:0]     LEN,
  input  logic [ADDR_W-1:0]    A_BASE,
  input  logic [ADDR_W-1:0]    B_BASE,
  npu_operand_feeder_if.master mem,
  output logic                 INPUT_EN,
  output logic [BYTE_W-1:0]    A_IN,
  output logic [BYTE_W-1:0]    B_IN,
  output logic                 BUSY,
  output logic                 DONE
);

  logic [1:0]        state,     state_d;
  logic [LEN_W-1:0]  remaining, remaining_d;
  logic [BIDX_W-1:0] byte_idx,  byte_idx_d;
  logic [ADDR_W-1:0] addr_a,    addr_a_d;
  logic [ADDR_W-1:0] addr_b,    addr_b_d;
  logic              mem_re,    mem_re_d;
  logic              rd_pend,   rd_pend_d;
  logic              nxt_valid, nxt_valid_d;
  logic              input_en_d, busy_d, done_d;
  logic              issue_c;
  logic              load_nxt_c;
  logic              src_rdata_c;

  assign mem.MEM_A_RE   = mem_re;
  assign mem.MEM_B_RE   = mem_re;
  assign mem.MEM_A_ADDR = addr_a;
  assign mem.MEM_B_ADDR = addr_b;

  // With no word buffered, byte 0 is taken from the read returning this cycle.
  assign src_rdata_c = !nxt_valid;

  // Next-state and next-register logic; A and B share all control.
  always_comb begin
    state_d     = state;
    remaining_d = remaining;
    byte_idx_d  = byte_idx;
    addr_a_d    = addr_a;
    addr_b_d    = addr_b;
    mem_re_d    = 1'b0;
    rd_pend_d   = mem_re;
    nxt_valid_d = nxt_valid;
    issue_c     = 1'b0;
    load_nxt_c  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (START) begin
          remaining_d = LEN;
          addr_a_d    = A_BASE;
          addr_b_d    = B_BASE;
          byte_idx_d  = '0;
          nxt_valid_d = 1'b0;
          if (LEN != '0) begin
            state_d  = ST_FETCH;
            mem_re_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_FETCH: begin
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        issue_c = !PAUSE && (remaining != '0) &&
                  ((byte_idx != '0) || nxt_valid || rd_pend);
        if (issue_c) begin
          remaining_d = remaining - 1'b1;
          byte_idx_d  = byte_idx + 1'b1;
          // Prefetch the next word on byte 1, only if elements remain past this word.
          if ((byte_idx == BIDX_W'(1)) && (remaining > LEN_W'(3))) begin
            mem_re_d = 1'b1;
            addr_a_d = addr_a + 1'b1;
            addr_b_d = addr_b + 1'b1;
          end
        end
        // Returning data parks in the next-word register unless consumed directly.
        load_nxt_c = rd_pend && !(issue_c && (byte_idx == '0) && src_rdata_c);
        if (issue_c && (byte_idx == '0)) begin
          nxt_valid_d = 1'b0;
        end else if (rd_pend) begin
          nxt_valid_d = 1'b1;
        end
        if (remaining == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort drops the job and any read still in flight.
    if (ABORT && (state != ST_IDLE)) begin
      state_d     = ST_IDLE;
      issue_c     = 1'b0;
      load_nxt_c  = 1'b0;
      mem_re_d    = 1'b0;
      rd_pend_d   = 1'b0;
      nxt_valid_d = 1'b0;
    end

    input_en_d = issue_c;
    busy_d     = (state_d == ST_FETCH) || (state_d == ST_STREAM);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge CLK or negedge rst_x) begin
    if (!rst_x) begin
      state     <= ST_IDLE;
      remaining <= '0;
      byte_idx  <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      mem_re    <= 1'b0;
      rd_pend   <= 1'b0;
      nxt_valid <= 1'b0;
      INPUT_EN  <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= remaining_d;
      byte_idx  <= byte_idx_d;
      addr_a    <= addr_a_d;
      addr_b    <= addr_b_d;
      mem_re    <= mem_re_d;
      rd_pend   <= rd_pend_d;
      nxt_valid <= nxt_valid_d;
      INPUT_EN  <= input_en_d;
      BUSY      <= busy_d;
      DONE      <= done_d;
    end
  end

  npu_word_unpacker u_unpack_a (
    .CLK       (CLK),
    .rst_x     (rst_x),
    .rdata     (mem.MEM_A_RDATA),
    .load_nxt  (load_nxt_c),
    .advance   (issue_c),
    .src_rdata (src_rdata_c),
    .byte_idx  (byte_idx),
    .elem      (A_IN)
  );

  npu_word_unpacker u_unpack_b (
    .CLK       (CLK),
    .rst_x     (rst_x),
    .rdata     (mem.MEM_B_RDATA),
    .load_nxt  (load_nxt_c),
    .advance   (issue_c),
    .src_rdata (src_rdata_c),
    .byte_idx  (byte_idx),
    .elem      (B_IN)
  );

endmodule

// File: tb/tb_npu_operand_feeder.sv
// Bench for npu_operand_feeder: SRAM models, element scoreboard, job scenarios.
module tb_npu_operand_feeder;
  import npu_pkg::*;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic               CLK = 1'b0;
  logic               rst_x;
  logic               START, ABORT, PAUSE;
  logic [LEN_W-1:0]   LEN;
  logic [ADDR_W-1:0]  A_BASE, B_BASE;
  logic               INPUT_EN, BUSY, DONE;
  logic [7:0]         A_IN, B_IN;

  npu_operand_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  npu_operand_feeder #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .rst_x(rst_x), .START(START), .ABORT(ABORT), .PAUSE(PAUSE),
    .LEN(LEN), .A_BASE(A_BASE), .B_BASE(B_BASE), .mem(bus),
    .INPUT_EN(INPUT_EN), .A_IN(A_IN), .B_IN(B_IN), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read SRAM models
  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] rdata_a = '0, rdata_b = '0;
  assign bus.MEM_A_RDATA = rdata_a;
  assign bus.MEM_B_RDATA = rdata_b;
  always @(posedge CLK) begin
    if (bus.MEM_A_RE) rdata_a <= mem_a[bus.MEM_A_ADDR];
    if (bus.MEM_B_RE) rdata_b <= mem_b[bus.MEM_B_ADDR];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Per-job observation log
  int                en_cnt, first_en_rel, last_en_rel, done_rel, done_cnt, busy_cnt;
  bit                done_seen;
  int                re_cyc[$];
  logic [ADDR_W-1:0] re_a[$];
  logic [ADDR_W-1:0] re_b[$];
  logic [15:0]       exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [15:0] e;
    if (INPUT_EN) begin
      if (en_cnt == 0) first_en_rel = cyc - t0;
      last_en_rel = cyc - t0;
      en_cnt++;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = 'x;
      chk("elem", 32'({A_IN, B_IN}), 32'(e));
    end
    if (DONE) begin
      done_cnt++;
      done_rel  = cyc - t0;
      done_seen = 1'b1;
    end
    if (BUSY) busy_cnt++;
    if (bus.MEM_A_RE) begin
      re_cyc.push_back(cyc - t0);
      re_a.push_back(bus.MEM_A_ADDR);
    end
    if (bus.MEM_B_RE) re_b.push_back(bus.MEM_B_ADDR);
  end

  task automatic clear_log();
    en_cnt = 0; first_en_rel = -1; last_en_rel = -1; done_rel = -1;
    done_cnt = 0; busy_cnt = 0; done_seen = 1'b0;
    re_cyc.delete(); re_a.delete(); re_b.delete();
  endtask

  // Issue a job; the scoreboard receives the model's expected element pairs.
  task automatic start_job(input int len, input logic [ADDR_W-1:0] ab, input logic [ADDR_W-1:0] bb);
    logic [ADDR_W-1:0] wa, wb;
    logic [31:0]       da, db;
    @(posedge CLK); #1;
    START = 1'b1; LEN = LEN_W'(len); A_BASE = ab; B_BASE = bb;
    t0 = cyc;
    clear_log();
    for (int i = 0; i < len; i++) begin
      wa = ADDR_W'(ab + ADDR_W'(i / 4));
      wb = ADDR_W'(bb + ADDR_W'(i / 4));
      da = mem_a[wa] >> (8 * (i % 4));
      db = mem_b[wb] >> (8 * (i % 4));
      exp_q.push_back({da[7:0], db[7:0]});
    end
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done_seen && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 1);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic chk_reads(input string tag, input int n, input logic [ADDR_W-1:0] a0,
                           input logic [ADDR_W-1:0] b0);
    chk({tag, "_nre_a"}, re_a.size(), n);
    chk({tag, "_nre_b"}, re_b.size(), n);
    for (int i = 0; i < n && i < re_a.size(); i++)
      chk({tag, "_addr_a"}, 32'(re_a[i]), 32'(ADDR_W'(a0 + ADDR_W'(i))));
    for (int i = 0; i < n && i < re_b.size(); i++)
      chk({tag, "_addr_b"}, 32'(re_b[i]), 32'(ADDR_W'(b0 + ADDR_W'(i))));
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ctl"}, 32'({INPUT_EN, BUSY, DONE, bus.MEM_A_RE, bus.MEM_B_RE}), 0);
    chk({tag, "_elem"}, 32'({A_IN, B_IN}), 0);
    chk({tag, "_addr"}, 32'({bus.MEM_A_ADDR, bus.MEM_B_ADDR}), 0);
  endtask

  task automatic chk_job(input string tag, input int len, input int done_at, input int busy_n);
    chk({tag, "_done_rel"}, done_rel, done_at);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_en_cnt"}, en_cnt, len);
    chk({tag, "_busy_cnt"}, busy_cnt, busy_n);
    chk({tag, "_q_left"}, exp_q.size(), 0);
  endtask

  initial begin
    START = 1'b0; ABORT = 1'b0; PAUSE = 1'b0; LEN = '0; A_BASE = '0; B_BASE = '0;
    clear_log();
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = $urandom;
    end
    mem_a[12'h010] = 32'h04030201;
    mem_a[12'h011] = 32'h08070605;
    mem_b[12'h020] = 32'h11111111;
    mem_b[12'h021] = 32'h11111111;

    rst_x = 1'b1;
    #2 rst_x = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero_outputs("reset");
    rst_x = 1'b1;
    repeat (2) @(posedge CLK);

    // 1: basic stream, two words, prefetch timing
    start_job(6, 12'h010, 12'h020);
    wait_done("t1", 40);
    chk_job("t1", 6, 9, 8);
    chk("t1_first_en", first_en_rel, 3);
    chk("t1_last_en", last_en_rel, 8);
    chk_reads("t1", 2, 12'h010, 12'h020);
    if (re_cyc.size() == 2) begin
      chk("t1_re_cyc0", re_cyc[0], 1);
      chk("t1_re_cyc1", re_cyc[1], 4);
    end

    // 2: zero-length job
    start_job(0, 12'h400, 12'h500);
    wait_done("t2", 20);
    chk_job("t2", 0, 1, 0);
    chk_reads("t2", 0, 12'h400, 12'h500);

    // 3: pause for 3 cycles starting at element 5
    start_job(16, 12'h200, 12'h300);
    repeat (7) @(posedge CLK);
    #1 PAUSE = 1'b1;
    repeat (3) @(posedge CLK);
    #1 PAUSE = 1'b0;
    wait_done("t3", 60);
    chk_job("t3", 16, 22, 21);
    chk("t3_first_en", first_en_rel, 3);
    chk("t3_last_en", last_en_rel, 21);
    chk_reads("t3", 4, 12'h200, 12'h300);

    // 4: abort during element 9, then a fresh job
    start_job(20, 12'h040, 12'h050);
    repeat (11) @(posedge CLK);
    #1 ABORT = 1'b1;
    @(posedge CLK);
    #1 ABORT = 1'b0;
    @(negedge CLK);
    chk("t4_en_after_abort", 32'(INPUT_EN), 0);
    chk("t4_busy_after_abort", 32'(BUSY), 0);
    repeat (10) @(negedge CLK);
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_en_cnt", en_cnt, 10);
    chk("t4_last_en", last_en_rel, 12);
    chk("t4_q_left", exp_q.size(), 10);
    exp_q.delete();
    start_job(4, 12'h060, 12'h070);
    wait_done("t4b", 30);
    chk_job("t4b", 4, 7, 6);
    chk_reads("t4b", 1, 12'h060, 12'h070);

    // 5: address wrap at the top of SRAM A
    start_job(8, 12'hFFF, 12'h7FE);
    wait_done("t5", 40);
    chk_job("t5", 8, 11, 10);
    chk_reads("t5", 2, 12'hFFF, 12'h7FE);

    // 6: START while busy is ignored
    start_job(12, 12'h100, 12'h200);
    repeat (3) @(posedge CLK);
    #1;
    START = 1'b1; LEN = LEN_W'(3); A_BASE = 12'h300; B_BASE = 12'h310;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done("t6", 50);
    chk_job("t6", 12, 15, 14);
    chk_reads("t6", 3, 12'h100, 12'h200);

    // 7: asynchronous reset mid-stream, then a clean job
    start_job(16, 12'h500, 12'h600);
    repeat (5) @(posedge CLK);
    #2 rst_x = 1'b0;
    #1;
    chk_zero_outputs("t7_rst");
    repeat (2) @(posedge CLK);
    #1 rst_x = 1'b1;
    exp_q.delete();
    start_job(5, 12'h0A0, 12'h0B0);
    wait_done("t7b", 30);
    chk_job("t7b", 5, 8, 7);
    chk_reads("t7b", 2, 12'h0A0, 12'h0B0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
